// File: rtl/haar_pkg.sv
// haar_pkg: types and default dimensions shared by the Haar pair feeder.
// Provides the feeder state enum, the default pixel width and the default frame size.
package haar_pkg;
    typedef enum logic [1:0] {IDLE, EVEN, ODD, GAP} haar_feed_state_t;
    localparam int HAAR_DATA_W     = 16;
    localparam int HAAR_IMG_WIDTH  = 256;
    localparam int HAAR_IMG_HEIGHT = 256;
endpackage

// File: rtl/haar_raster_counter.sv
// haar_raster_counter: column/row position tracker for the Haar pair feeder.
// Ports: clk, reset (sync, active-low), clr (restart at column 0 of row 0),
//        col_adv (a pair completed), row_adv (row separator cycle),
//        last_col / last_row (current pair / row is the last one), row_fwd (current row is forwarded).
// Macro HAAR_ROW_DECIM_EN: when defined, only even rows are forwarded.
module haar_raster_counter
    import haar_pkg::*;
#(
    parameter int IMG_WIDTH  = HAAR_IMG_WIDTH,
    parameter int IMG_HEIGHT = HAAR_IMG_HEIGHT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic col_adv,
    input  logic row_adv,
    output logic last_col,
    output logic last_row,
    output logic row_fwd
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    assign last_col = col_q == CW'(IMG_WIDTH - 2);
    assign last_row = row_q == RW'(IMG_HEIGHT - 1);
`ifdef HAAR_ROW_DECIM_EN
    assign row_fwd = ~row_q[0];
`else
    assign row_fwd = 1'b1;
`endif
    // Explicit wrap keeps non-power-of-two dimensions correct.
    always_comb begin
        col_d = clr ? '0 : col_adv ? (last_col ? '0 : col_q + CW'(2)) : col_q;
        row_d = clr ? '0 : row_adv ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/haar_pair_feeder.sv
// haar_pair_feeder: groups a raster pixel stream into (even, odd) pairs for haar_lift.
// Ports: clk, reset (sync, active-low); pix_valid/pix_sof/pix_data/pix_ready pixel handshake;
//        start/im11/im21 registered pair to haar_lift; row_done/frame_done end-of-row/frame pulses.
// Macro HAAR_ROW_DECIM_EN: when defined, odd rows are consumed without emitting pairs.
module haar_pair_feeder
    import haar_pkg::*;
#(
    parameter int DATA_W     = HAAR_DATA_W,
    parameter int IMG_WIDTH  = HAAR_IMG_WIDTH,
    parameter int IMG_HEIGHT = HAAR_IMG_HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              start,
    output logic [DATA_W-1:0] im11,
    output logic [DATA_W-1:0] im21,
    output logic              row_done,
    output logic              frame_done
);
    haar_feed_state_t state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d, im11_q, im11_d, im21_q, im21_d;
    logic start_q, start_d, row_done_q, row_done_d, frame_done_q, frame_done_d;
    logic acc, clr, col_adv, row_adv, last_col, last_row, row_fwd;

    haar_raster_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_cnt (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .col_adv(col_adv),
        .row_adv(row_adv),
        .last_col(last_col),
        .last_row(last_row),
        .row_fwd(row_fwd)
    );

    assign pix_ready = state_q != GAP;

    // A sof pixel in any accepting state restarts the frame as column 0 of row 0.
    // Row/frame done of a dropped final row still fire, in its GAP cycle with start low.
    always_comb begin
        acc          = pix_valid && pix_ready;
        clr          = acc && pix_sof;
        col_adv      = acc && !pix_sof && state_q == ODD;
        row_adv      = state_q == GAP;
        hold_d       = (clr || (acc && state_q == EVEN)) ? pix_data : hold_q;
        start_d      = col_adv && row_fwd;
        im11_d       = start_d ? hold_q : im11_q;
        im21_d       = start_d ? pix_data : im21_q;
        row_done_d   = col_adv && last_col && (row_fwd || last_row);
        frame_done_d = col_adv && last_col && last_row;
        state_d      = state_q;
        case (state_q)
            EVEN:    if (acc) state_d = ODD;
            ODD:     if (acc) state_d = last_col ? GAP : EVEN;
            GAP:     state_d = last_row ? IDLE : EVEN;
            default: state_d = state_q;
        endcase
        if (clr) state_d = ODD;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            im11_q       <= '0;
            im21_q       <= '0;
            start_q      <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            im11_q       <= im11_d;
            im21_q       <= im21_d;
            start_q      <= start_d;
            row_done_q   <= row_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign start      = start_q;
    assign im11       = im11_q;
    assign im21       = im21_q;
    assign row_done   = row_done_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_haar_pair_feeder.sv
// tb_haar_pair_feeder: directed bench for haar_pair_feeder on a 4x4 and a 256x256 instance.
module tb_haar_pair_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, s_sof = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, s_start, s_rd, s_fd;
    logic [15:0] s_im11, s_im21;

    logic        b_valid = 1'b0, b_sof = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_start, b_rd, b_fd;
    logic [15:0] b_im11, b_im21;

    haar_pair_feeder #(.DATA_W(16), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_small (
        .clk(clk), .reset(reset), .pix_valid(s_valid), .pix_sof(s_sof), .pix_data(s_data),
        .pix_ready(s_ready), .start(s_start), .im11(s_im11), .im21(s_im21),
        .row_done(s_rd), .frame_done(s_fd)
    );

    haar_pair_feeder #(.DATA_W(16), .IMG_WIDTH(256), .IMG_HEIGHT(256)) u_big (
        .clk(clk), .reset(reset), .pix_valid(b_valid), .pix_sof(b_sof), .pix_data(b_data),
        .pix_ready(b_ready), .start(b_start), .im11(b_im11), .im21(b_im21),
        .row_done(b_rd), .frame_done(b_fd)
    );

    int nvec = 0, nerr = 0;
    logic [33:0] seen[$], want_q[$];
    int s_fd_cnt = 0, s_rd_cnt = 0, s_gapfd = 0, s_viol = 0;
    logic prev_rd = 1'b0;
    int nb_start = 0, nb_rdfwd = 0, nb_fd = 0, nb_lowrdy = 0, nb_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge and logged.
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_start) seen.push_back({s_rd, s_fd, s_im11, s_im21});
        if (s_fd) s_fd_cnt++;
        if (s_fd && s_rd && !s_start) s_gapfd++;
        if (s_rd) s_rd_cnt++;
        if (prev_rd && s_start) s_viol++;
        prev_rd = s_rd;
        if (b_start) begin
            nb_start++;
            if (b_rd) nb_rdfwd++;
            if (b_im11[0] || b_im21 != 16'(b_im11 + 16'd1)) nb_bad++;
`ifdef HAAR_ROW_DECIM_EN
            if (b_im11[8]) nb_bad++;
`endif
        end
        if (b_fd) nb_fd++;
        if (!b_ready) nb_lowrdy++;
    endtask

    task automatic clr_log();
        seen.delete();
        s_fd_cnt = 0;
        s_rd_cnt = 0;
        s_gapfd = 0;
    endtask

    task automatic s_send(input logic [15:0] d, input logic sof, input bit gap);
        bit acc;
        int n;
        if (gap) begin
            s_valid = 1'b0;
            tick();
        end
        s_valid = 1'b1;
        s_sof = sof;
        s_data = d;
        n = 0;
        do begin
            acc = s_ready;
            tick();
            n++;
        end while (!acc && n < 8);
        if (!acc) chk("s_accept_timeout", {63'b0, acc}, 64'd1);
        s_sof = 1'b0;
    endtask

    task automatic s_idle(input int n);
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_pairs(input string tag);
        chk($sformatf("%s_npairs", tag), seen.size(), want_q.size());
        for (int k = 0; k < want_q.size() && k < seen.size(); k++)
            chk($sformatf("%s_pair%0d", tag, k), seen[k], want_q[k]);
    endtask

    initial begin
        bit acc;
        int n;
        tick();
        tick();
        chk("rst_outputs", {s_start, s_rd, s_fd, s_im11, s_im21}, 0);
        reset = 1'b1;
        chk("rst_ready", s_ready, 1);

        // Ramp 4x4, continuous valid
        clr_log();
        for (int i = 0; i < 16; i++) s_send(16'(i), i == 0, 0);
        s_idle(4);
`ifdef HAAR_ROW_DECIM_EN
        want_q = '{{2'b00, 16'h0, 16'h1}, {2'b10, 16'h2, 16'h3},
                   {2'b00, 16'h8, 16'h9}, {2'b10, 16'hA, 16'hB}};
        chk("ramp_rd_cnt", s_rd_cnt, 3);
        chk("ramp_gap_fd", s_gapfd, 1);
`else
        want_q = '{{2'b00, 16'h0, 16'h1}, {2'b10, 16'h2, 16'h3},
                   {2'b00, 16'h4, 16'h5}, {2'b10, 16'h6, 16'h7},
                   {2'b00, 16'h8, 16'h9}, {2'b10, 16'hA, 16'hB},
                   {2'b00, 16'hC, 16'hD}, {2'b11, 16'hE, 16'hF}};
        chk("ramp_rd_cnt", s_rd_cnt, 4);
        chk("ramp_gap_fd", s_gapfd, 0);
`endif
        chk_pairs("ramp");
        chk("ramp_fd_cnt", s_fd_cnt, 1);

        // Same frame, valid toggling every other cycle
        clr_log();
        for (int i = 0; i < 16; i++) s_send(16'(i), i == 0, 1);
        s_idle(4);
        chk_pairs("toggle");
        chk("toggle_fd_cnt", s_fd_cnt, 1);

        // sof re-asserted at column 3 of row 1 aborts the frame
        clr_log();
        for (int i = 0; i < 7; i++) s_send(16'(i), i == 0, 0);
        s_send(16'h00AA, 1, 0);
        for (int i = 1; i < 16; i++) s_send(16'(16'h0100 + i), 0, 0);
        s_idle(4);
`ifdef HAAR_ROW_DECIM_EN
        want_q = '{{2'b00, 16'h0, 16'h1}, {2'b10, 16'h2, 16'h3},
                   {2'b00, 16'hAA, 16'h101}, {2'b10, 16'h102, 16'h103},
                   {2'b00, 16'h108, 16'h109}, {2'b10, 16'h10A, 16'h10B}};
`else
        want_q = '{{2'b00, 16'h0, 16'h1}, {2'b10, 16'h2, 16'h3},
                   {2'b00, 16'h4, 16'h5},
                   {2'b00, 16'hAA, 16'h101}, {2'b10, 16'h102, 16'h103},
                   {2'b00, 16'h104, 16'h105}, {2'b10, 16'h106, 16'h107},
                   {2'b00, 16'h108, 16'h109}, {2'b10, 16'h10A, 16'h10B},
                   {2'b00, 16'h10C, 16'h10D}, {2'b11, 16'h10E, 16'h10F}};
`endif
        chk_pairs("abort");
        chk("abort_fd_cnt", s_fd_cnt, 1);

        // Reset one cycle after an even pixel
        s_send(16'h0055, 1, 0);
        s_valid = 1'b0;
        reset = 1'b0;
        tick();
        chk("midrst_outputs", {s_start, s_rd, s_fd, s_im11, s_im21}, 0);
        chk("midrst_ready", s_ready, 1);
        reset = 1'b1;
        clr_log();
        for (int i = 0; i < 4; i++) s_send(16'(16'h0060 + i), 0, 0);
        s_idle(2);
        chk("midrst_no_start", seen.size(), 0);
        s_send(16'h0070, 1, 0);
        s_send(16'h0071, 0, 0);
        s_idle(2);
        want_q = '{{2'b00, 16'h70, 16'h71}};
        chk_pairs("midrst");
        chk("row_gap_viol", s_viol, 0);

        // 256x256 frame, continuous valid
        nb_lowrdy = 0;
        for (int i = 0; i < 65536; i++) begin
            b_valid = 1'b1;
            b_sof = i == 0;
            b_data = 16'(i);
            n = 0;
            do begin
                acc = b_ready;
                tick();
                n++;
            end while (!acc && n < 8);
            if (!acc) begin
                chk("big_accept_timeout", {63'b0, acc}, 64'd1);
                break;
            end
        end
        b_valid = 1'b0;
        b_sof = 1'b0;
        for (int i = 0; i < 4; i++) tick();
`ifdef HAAR_ROW_DECIM_EN
        chk("big_start_cnt", nb_start, 16384);
        chk("big_rd_cnt", nb_rdfwd, 128);
`else
        chk("big_start_cnt", nb_start, 32768);
        chk("big_rd_cnt", nb_rdfwd, 256);
`endif
        chk("big_fd_cnt", nb_fd, 1);
        chk("big_ready_low", nb_lowrdy, 256);
        chk("big_pair_data", nb_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/haar_pair_feeder.md
# haar_pair_feeder

Upstream feeder for `haar_lift`.
- Accepts a raster-order pixel stream over a valid/ready handshake.
- Groups horizontally adjacent pixels into (even, odd) pairs and drives `start`/`im11`/`im21` into the lifting stage.
- Forces a one-cycle `start` gap at every row boundary.
- Optionally decimates odd rows, so a 256x256 frame yields 128 forwarded rows of 128 pairs (16384 pairs).

## Interface
- `DATA_W`, 16, pixel width; equals `haar_lift` input width.
- `IMG_WIDTH`, 256, pixels per row; must be even and ≥ 2.
- `IMG_HEIGHT`, 256, rows per frame; must be ≥ 1 (≥ 2 when decimation is compiled in).
- Clock: `clk`, one clock domain. Reset: `reset`, synchronous, active-low.
- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low.
- `pix_valid`  in  1  pixel present on `pix_data`.
- `pix_sof`  in  1  qualifies the current pixel as the first pixel of a frame.
- `pix_data`  in  DATA_W  pixel value.
- `pix_ready`  out  1  feeder accepts a pixel this cycle.
- `start`  out  1  pair valid; connects to `haar_lift.start`.
- `im11`  out  DATA_W  even-column pixel of the pair.
- `im21`  out  DATA_W  odd-column pixel of the pair.
- `row_done`  out  1  one-cycle pulse, coincident with the last pair of a forwarded row.
- `frame_done`  out  1  one-cycle pulse, coincident with the last pair of the frame.

## Operation
- Transfer happens when `pix_valid && pix_ready` at a posedge.
- FSM states:
  - IDLE: waiting for a pixel with `pix_sof`.
  - EVEN: next accepted pixel is an even column.
  - ODD: next accepted pixel is an odd column.
  - GAP: one-cycle row separator.
- IDLE: `pix_ready`=1.
  - Pixel accepted with `pix_sof`=1: treated as column 0 of row 0; stored in hold register; go to ODD.
  - Pixel accepted with `pix_sof`=0: discarded, stay in IDLE.
- EVEN: accepted pixel goes to hold register; go to ODD.
- ODD: accepted pixel completes the pair.
  - Next cycle: `im11`=hold, `im21`=pixel, `start`=1, provided the row is forwarded.
  - Column counter advances by 2.
  - At column IMG_WIDTH-2: go to GAP. Otherwise go to EVEN.
- GAP: `pix_ready`=0 for exactly one cycle.
  - Row counter increments.
  - Go to EVEN, or to IDLE if the row just finished was row IMG_HEIGHT-1.
- `pix_sof`=1 on an accepted pixel in EVEN, ODD or GAP-exit:
  - Abort the current frame; discard the held pixel.
  - Reset counters; take the pixel as column 0 of row 0.
  - No `row_done`/`frame_done` is emitted for the aborted frame.
- Dropped rows are still consumed at full rate and still take a GAP cycle; `start` stays 0 for them.
- Counter widths: column `$clog2(IMG_WIDTH)`, row `$clog2(IMG_HEIGHT)`. Both wrap to 0 at end of row/frame. No arithmetic on pixel data; values pass bit-exact.

## Timing
- Reset (`reset`=0 at posedge): state=IDLE, counters=0, hold=0, `im11`=0, `im21`=0, `start`=0, `row_done`=0, `frame_done`=0.
- `pix_ready`=1 in the first cycle after reset is released (IDLE).
- Reset mid-row: the partial pair is discarded; no `start` follows.
- Latency: the odd pixel accepted at edge N gives `start`=1 for the cycle after edge N.
- `start` is never high for two cycles that belong to different rows. Between rows there is ≥1 `start`=0 cycle.
- `im11`/`im21` hold their value when `start`=0.
- `pix_ready` is combinational from state only, never from `pix_valid`.
- Maximum throughput: one pixel per cycle, i.e. one pair every 2 cycles, plus 1 gap cycle per row.
- `frame_done` and `row_done` both assert with the final pair. If the final row is dropped, they assert together in the GAP cycle with `start`=0.

## Configuration
- `HAAR_ROW_DECIM_EN` defined: only even rows (row counter bit 0 = 0) are forwarded; odd rows are consumed silently.
- Not defined: every row is forwarded.
- IMG_WIDTH=IMG_HEIGHT=256:
  - With the macro: 16384 `start` pulses per frame.
  - Without it: 32768 `start` pulses per frame.

## Structure
- Shared package `haar_pkg`:
  - `haar_feed_state_t` enum (IDLE, EVEN, ODD, GAP).
  - `HAAR_DATA_W` = 16.
  - Default image dimension constants.
- One sub-module, `haar_raster_counter`:
  - Column/row counters with wrap.
  - `last_col`, `last_row` and `row_fwd` flags.
  - The `HAAR_ROW_DECIM_EN` decision lives here.

## Test plan
- Ramp frame 4x4, pixels 0..15, continuous valid, macro on:
  - pairs (0,1),(2,3),(8,9),(10,11); `row_done` after pairs (2,3) and (10,11).
  - `frame_done` in the GAP cycle after row 3 (dropped final row), coincident with `row_done`.
  - `start` low between rows.
- Same frame, macro off: 8 pairs, last pair (14,15) with `frame_done`=1 coincident with it.
- `pix_valid` toggling every other cycle: same pair sequence; `start` only after the odd pixel.
- `pix_sof` reasserted at column 3 of row 1 (pixel 0x00AA): held pixel dropped; first new pair `im11`=0x00AA; no `frame_done` for the aborted frame.
- `reset`=0 for one cycle after an even pixel: all outputs 0 next cycle; no `start`; non-sof pixels discarded until `pix_sof`.
- 256x256 frame of the test image, macro on: exactly 16384 `start` pulses, 128 `row_done` pulses, 1 `frame_done`; `pix_ready` low exactly 256 cycles.
